// File: rtl/rv_fetch_ctrl_if.sv
// Fetch-control bundle: redirect, aligner handshake, decode handoff, counters.
// master = fetch controller, slave = surrounding pipeline / aligner.
interface rv_fetch_ctrl_if;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic        i_stall;
  logic        i_move;
  logic [31:0] i_pc_incr;
  logic        i_al_ready;
  logic [31:0] i_al_pc;
  logic [31:0] i_al_instr;
  logic        o_start;
  logic        o_pc_select;
  logic [31:0] o_pc;
  logic        o_valid;
  logic [31:0] o_dec_pc;
  logic [31:0] o_dec_instr;
  logic [31:0] o_perf_fetched;
  logic [15:0] o_perf_flushes;
  logic [31:0] o_perf_stalls;

  modport master (
    input  i_flush, i_flush_pc, i_stall, i_move, i_pc_incr,
    input  i_al_ready, i_al_pc, i_al_instr,
    output o_start, o_pc_select, o_pc,
    output o_valid, o_dec_pc, o_dec_instr,
    output o_perf_fetched, o_perf_flushes, o_perf_stalls
  );

  modport slave (
    output i_flush, i_flush_pc, i_stall, i_move, i_pc_incr,
    output i_al_ready, i_al_pc, i_al_instr,
    input  o_start, o_pc_select, o_pc,
    input  o_valid, o_dec_pc, o_dec_instr,
    input  o_perf_fetched, o_perf_flushes, o_perf_stalls
  );
endinterface

// File: rtl/rv_fetch_ctrl.sv
// Fetch controller: PC sequencing, redirect FSM, 2-entry decode FIFO.
// Perf counters exist only when RV_FETCH_PERF_EN is defined.
module rv_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  rv_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_FLUSH1,
    ST_FLUSH2
  } state_t;

  state_t      state, state_nx;
  logic        run, flush_acc, push, pop;
  logic [31:0] pc;
  logic [31:0] fq_pc  [2];
  logic [31:0] fq_ins [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        unused_flush_lsb;

  assign unused_flush_lsb = bus.i_flush_pc[0];

  assign run       = (state == ST_RUN);
  assign flush_acc = bus.i_flush & (state != ST_RESET);
  assign push      = bus.i_al_ready & run & ~flush_acc;
  assign pop       = bus.o_valid & ~bus.i_stall;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RESET:  state_nx = ST_RUN;
      ST_RUN:    state_nx = ST_RUN;
      ST_FLUSH1: state_nx = ST_FLUSH2;
      ST_FLUSH2: state_nx = ST_RUN;
      default:   state_nx = ST_RESET;
    endcase
    if (flush_acc)
      state_nx = ST_FLUSH1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      state <= ST_RESET;
    else
      state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      pc <= RESET_VECTOR;
    else if (flush_acc)
      pc <= {bus.i_flush_pc[31:1], 1'b0};
    else if (bus.i_move && run)
      pc <= pc + bus.i_pc_incr;
  end

  // Storage needs no reset: entries are masked by count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fq_pc[wr_ptr]  <= bus.i_al_pc;
      fq_ins[wr_ptr] <= bus.i_al_instr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || flush_acc) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.o_pc        = pc;
  assign bus.o_pc_select = flush_acc;
  assign bus.o_valid     = (count != 2'd0);
  assign bus.o_dec_pc    = bus.o_valid ? fq_pc[rd_ptr]  : 32'h0;
  assign bus.o_dec_instr = bus.o_valid ? fq_ins[rd_ptr] : 32'h0;
  assign bus.o_start     = run & ~bus.i_flush &
                           ((count == 2'd0) |
                            ((count == 2'd1) & pop));

`ifdef RV_FETCH_PERF_EN
  logic [31:0] n_fetch;
  logic [15:0] n_flush;
  logic [31:0] n_stall;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      n_fetch <= 32'h0;
      n_flush <= 16'h0;
      n_stall <= 32'h0;
    end else begin
      if (pop && !flush_acc)
        n_fetch <= n_fetch + 32'd1;
      if (flush_acc)
        n_flush <= n_flush + 16'd1;
      if (bus.o_valid && bus.i_stall)
        n_stall <= n_stall + 32'd1;
    end
  end

  assign bus.o_perf_fetched = n_fetch;
  assign bus.o_perf_flushes = n_flush;
  assign bus.o_perf_stalls  = n_stall;
`else
  assign bus.o_perf_fetched = 32'h0;
  assign bus.o_perf_flushes = 16'h0;
  assign bus.o_perf_stalls  = 32'h0;
`endif

  a_no_push_full: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
      !(push && count == 2'd2)
  );

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Randomized bench for rv_fetch_ctrl against a queue-based fetch model.
// Perf expectations follow RV_FETCH_PERF_EN as compiled.
module tb_rv_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  rv_fetch_ctrl_if bus ();

  rv_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] q [$];
  logic [31:0] m_pc;
  bit          m_rst;
  bit          known;
  int          blind;
  logic [31:0] p_fetch;
  logic [15:0] p_flush;
  logic [31:0] p_stall;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    bit          run, acc, val, pop, st, nxt, spur;
    logic [63:0] hd;
    logic [31:0] npc, nins;
    @(negedge clk);
    run = known && !m_rst && blind == 0;
    acc = known && !m_rst && bus.i_flush;
    val = q.size() != 0;
    hd  = val ? q[0] : 64'h0;
    pop = val && !bus.i_stall;
    st  = run && !bus.i_flush &&
          (q.size() == 0 || (q.size() == 1 && pop));
    if (known) begin
      chk("pc",      bus.o_pc,           m_pc);
      chk("start",   {31'h0, bus.o_start},     {31'h0, st});
      chk("pc_sel",  {31'h0, bus.o_pc_select}, {31'h0, acc});
      chk("valid",   {31'h0, bus.o_valid},     {31'h0, val});
      chk("dec_pc",  bus.o_dec_pc,       hd[63:32]);
      chk("dec_ins", bus.o_dec_instr,    hd[31:0]);
`ifdef RV_FETCH_PERF_EN
      chk("perf_fetched", bus.o_perf_fetched, p_fetch);
      chk("perf_flushes", {16'h0, bus.o_perf_flushes}, {16'h0, p_flush});
      chk("perf_stalls",  bus.o_perf_stalls,  p_stall);
`else
      chk("perf_fetched", bus.o_perf_fetched, 32'h0);
      chk("perf_flushes", {16'h0, bus.o_perf_flushes}, 32'h0);
      chk("perf_stalls",  bus.o_perf_stalls,  32'h0);
`endif
    end
    nxt  = st && ($urandom_range(0, 3) != 0);
    npc  = m_pc;
    nins = $urandom;
    if (!rst_n) begin
      q.delete();
      m_pc    = RV;
      m_rst   = 1'b1;
      blind   = 0;
      known   = 1'b1;
      p_fetch = '0;
      p_flush = '0;
      p_stall = '0;
    end else if (known) begin
      if (val && bus.i_stall)
        p_stall++;
      if (acc) begin
        q.delete();
        m_pc  = {bus.i_flush_pc[31:1], 1'b0};
        blind = 2;
        p_flush++;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          p_fetch++;
        end
        if (run && bus.i_al_ready) begin
          if (q.size() >= 2)
            chk("overflow", q.size(), 1);
          q.push_back({bus.i_al_pc, bus.i_al_instr});
        end
        if (run && bus.i_move)
          m_pc = m_pc + bus.i_pc_incr;
        if (blind > 0)
          blind--;
        m_rst = 1'b0;
      end
    end
    // Results aimed at a blind cycle must be dropped by the DUT.
    spur = !nxt && (m_rst || blind > 0) && ($urandom_range(0, 1) == 1);
    @(posedge clk);
    #1;
    bus.i_al_ready = nxt || spur;
    bus.i_al_pc    = nxt ? npc : $urandom;
    bus.i_al_instr = nins;
  endtask

  int incr_tab [3] = '{4, 2, 4};

  initial begin
    rst_n          = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_flush_pc = 32'h0;
    bus.i_stall    = 1'b0;
    bus.i_move     = 1'b0;
    bus.i_pc_incr  = 32'd4;
    bus.i_al_ready = 1'b0;
    bus.i_al_pc    = 32'h0;
    bus.i_al_instr = 32'h0;
    known = 1'b0;
    m_rst = 1'b1;
    blind = 0;
    m_pc  = RV;
    p_fetch = '0;
    p_flush = '0;
    p_stall = '0;

    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_start_c1", {31'h0, bus.o_start}, 32'h1);
    bus.i_move = 1'b1;
    foreach (incr_tab[i]) begin
      bus.i_pc_incr = incr_tab[i];
      step();
    end
    chk("pc_stream", bus.o_pc, 32'h0000_010A);
    repeat (4) step();
    chk("stream_valid", {31'h0, bus.o_valid}, 32'h1);

    bus.i_move  = 1'b0;
    bus.i_stall = 1'b1;
    repeat (5) step();
    chk("stall_full_start", {31'h0, bus.o_start}, 32'h0);
    bus.i_stall = 1'b0;
    repeat (4) step();

    bus.i_flush    = 1'b1;
    bus.i_flush_pc = 32'h0000_2003;
    bus.i_move     = 1'b1;
    step();
    bus.i_flush = 1'b0;
    chk("flush_pc", bus.o_pc, 32'h0000_2002);
    chk("flush_empty", {31'h0, bus.o_valid}, 32'h0);
    step();
    step();
    step();

    bus.i_flush    = 1'b1;
    bus.i_flush_pc = 32'h0000_2400;
    step();
    bus.i_flush = 1'b0;
    step();
    bus.i_flush    = 1'b1;
    bus.i_flush_pc = 32'h0000_3000;
    step();
    bus.i_flush = 1'b0;
    chk("flush2_pc", bus.o_pc, 32'h0000_3000);
    repeat (4) step();

    for (int c = 0; c < 4000; c++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      bus.i_flush    = ($urandom_range(0, 15) == 0);
      bus.i_flush_pc = $urandom;
      bus.i_stall    = ($urandom_range(0, 2) == 0);
      bus.i_move     = $urandom_range(0, 1);
      bus.i_pc_incr  = $urandom_range(0, 1) ? 32'd4 : 32'd2;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
